// File: rtl/int_arith_pkg.sv
// -----------------------------------------------------------------------------
// int_arith_pkg
//
// Shared types for the iterative integer units of the FPU integer datapath
// (the Booth multiplier and its companion divider).
//
// Contents:
//   arith_state_t - IDLE / RUN / DONE sequencing states (2-bit encoding).
//   booth_op_t    - action selected by one radix-2 Booth recoding step.
//   booth_decode  - maps a Booth pair {current LSB, previous LSB} to an action.
// -----------------------------------------------------------------------------
package int_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding: the pair is {multiplier bit i, multiplier bit i-1}.
    // A 0->1 transition going up (pair 10) starts a run of ones and subtracts;
    // the end of a run (pair 01) adds.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/int_mul_booth_step.sv
// -----------------------------------------------------------------------------
// int_mul_booth_step
//
// One combinational radix-2 Booth step for the iterative multiplier.
//
// The accumulator is 2*WIDTH+2 bits: the upper WIDTH+1 bits hold the running
// partial product, the lower WIDTH+1 bits hold the not-yet-consumed multiplier
// bits (LSB first). The step adds/subtracts the extended multiplicand into the
// upper part, then shifts the whole accumulator right arithmetically by one.
//
// Ports:
//   acc_i   [2*WIDTH+1:0] - current accumulator.
//   ext_a_i [WIDTH:0]     - multiplicand, already sign/zero-extended.
//   pair_i  [1:0]         - Booth pair {current multiplier LSB, previous LSB}.
//   acc_o   [2*WIDTH+1:0] - accumulator after add/sub and shift.
// -----------------------------------------------------------------------------
module int_mul_booth_step
    import int_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+1:0] acc_i,
    input  logic [WIDTH:0]     ext_a_i,
    input  logic [1:0]         pair_i,
    output logic [2*WIDTH+1:0] acc_o
);

    localparam int ACC_W = 2 * WIDTH + 2;

    booth_op_t        op;
    logic [WIDTH+1:0] hi_wide;
    logic [WIDTH+1:0] a_wide;
    logic [WIDTH+1:0] sum;

    // The add/subtract is done one bit wider than the partial product so the
    // true sign of the sum survives even when the WIDTH+1-bit result would
    // overflow; that extra bit becomes the sign fed in by the arithmetic shift.
    always_comb begin
        op      = booth_decode(pair_i);
        hi_wide = {acc_i[ACC_W-1], acc_i[ACC_W-1:WIDTH+1]};
        a_wide  = {ext_a_i[WIDTH], ext_a_i};
        sum     = hi_wide;
        case (op)
            BOOTH_ADD: sum = hi_wide + a_wide;
            BOOTH_SUB: sum = hi_wide - a_wide;
            default:   sum = hi_wide;
        endcase
        // Dropping the shifted-out multiplier bit completes the shift; the
        // widened sum occupies the top of the next accumulator.
        acc_o = ACC_W'({sum, acc_i[WIDTH:0]} >> 1);
    end

endmodule

// File: rtl/int_mul.sv
// -----------------------------------------------------------------------------
// int_mul
//
// Iterative sequential integer multiplier using radix-2 Booth recoding, one
// step per clock. Produces the full 2*WIDTH-bit product of two WIDTH-bit
// operands, each independently signed or unsigned. Uses the same start/valid
// handshake as the iterative divider.
//
// Both operands are extended to WIDTH+1 bits (sign- or zero-extension per
// their flag), so every operand combination becomes a signed WIDTH+1 x WIDTH+1
// multiply whose exact result always fits in the 2*WIDTH+2-bit accumulator.
//
// Timing: start accepted at edge 0, RUN spans WIDTH+1 steps, DONE registers
// the product and valid_o is high in the cycle after edge WIDTH+2.
//
// Ports:
//   clk_i        - clock, rising edge.
//   reset_i      - asynchronous reset, active high; aborts any operation.
//   start_i      - request, sampled only in IDLE.
//   a_i, b_i     - multiplicand / multiplier (WIDTH bits).
//   a_signed_i   - 1: a_i is two's complement, 0: unsigned (sampled with start).
//   b_signed_i   - same for b_i.
//   p_lo_o       - product bits [WIDTH-1:0], held until next result or reset.
//   p_hi_o       - product bits [2*WIDTH-1:WIDTH], held likewise.
//   busy_o       - high whenever the unit is not IDLE.
//   valid_o      - one-cycle pulse when p_lo_o/p_hi_o take a new result.
// -----------------------------------------------------------------------------
module int_mul
    import int_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             a_signed_i,
    input  logic             b_signed_i,
    output logic [WIDTH-1:0] p_lo_o,
    output logic [WIDTH-1:0] p_hi_o,
    output logic             busy_o,
    output logic             valid_o
);

    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    arith_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [WIDTH:0]   ext_a_q, ext_a_d;
    logic             prev_q,  prev_d;
    logic [WIDTH-1:0] p_lo_q,  p_lo_d;
    logic [WIDTH-1:0] p_hi_q,  p_hi_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   ext_a_in;
    logic [WIDTH:0]   ext_b_in;
    logic [ACC_W-1:0] acc_step;

    // The extension bit is the operand MSB only when that operand is signed;
    // otherwise the operand is treated as a non-negative WIDTH+1-bit value.
    always_comb begin
        ext_a_in = {a_signed_i & a_i[WIDTH-1], a_i};
        ext_b_in = {b_signed_i & b_i[WIDTH-1], b_i};
    end

    int_mul_booth_step #(
        .WIDTH (WIDTH)
    ) u_booth_step (
        .acc_i   (acc_q),
        .ext_a_i (ext_a_q),
        .pair_i  ({acc_q[0], prev_q}),
        .acc_o   (acc_step)
    );

    // Next-state and datapath control. The multiplier is loaded into the low
    // half of the accumulator with the partial-product half cleared, so each
    // Booth step consumes the multiplier LSB as the shift pulls the product in.
    // The counter starts at WIDTH and the step at count zero still executes,
    // giving the WIDTH+1 steps a WIDTH+1-bit multiplier needs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ext_a_d = ext_a_q;
        prev_d  = prev_q;
        p_lo_d  = p_lo_q;
        p_hi_d  = p_hi_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    ext_a_d = ext_a_in;
                    acc_d   = {{(WIDTH + 1){1'b0}}, ext_b_in};
                    prev_d  = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            RUN: begin
                acc_d  = acc_step;
                prev_d = acc_q[0];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                p_lo_d  = acc_q[WIDTH-1:0];
                p_hi_d  = acc_q[2*WIDTH-1:WIDTH];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, which also
    // guarantees an aborted operation can never produce a valid pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ext_a_q <= '0;
            prev_q  <= 1'b0;
            p_lo_q  <= '0;
            p_hi_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ext_a_q <= ext_a_d;
            prev_q  <= prev_d;
            p_lo_q  <= p_lo_d;
            p_hi_q  <= p_hi_d;
            valid_q <= valid_d;
        end
    end

    assign p_lo_o  = p_lo_q;
    assign p_hi_o  = p_hi_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);

endmodule
